// File: rtl/gatebach_host.sv
// gatebach_host: host-side initiator that streams a prime table into a gatebach_core,
// kicks one fragment at a time and captures the 64 result words for the host to read.
module gatebach_host #(
   parameter int          CORE_NUM  = 1,
   parameter int          FRAG_NUM  = 1,
   parameter logic [63:0] ADDR_STEP = 64'd4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_start,
   input  logic [63:0] cfg_base_addr,
   input  logic        prime_we,
   input  logic [4:0]  prime_idx,
   input  logic [31:0] prime_data,
   input  logic        rd_en,
   input  logic [5:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        frag_ready,
   input  logic        frag_ack,
   output logic [21:0] frag_cnt,
   output logic        busy,
   output logic        intr,
   input  logic        intr_clr,
   output logic        core_cs,
   output logic [4:0]  core_add,
   output logic [31:0] core_data,
   output logic [63:0] core_start_addr,
   output logic        core_kick_start,
   input  logic        core_store_done,
   input  logic        core_load_done,
   input  logic        core_proc_done,
   input  logic        res_cs,
   input  logic [5:0]  res_add,
   input  logic [31:0] res_data
);
   typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT_STORE, FRAG_READY, DONE} state_t;
   state_t      state, state_nx;
   logic [4:0]  idx;
   logic        store_prev;
   logic [31:0] prime_tab [32];
   logic [31:0] res_buf [64];
   logic        start_ok, last_load, store_edge, ack_ok, last_frag;
   logic        unused_ok;
   assign unused_ok  = &{core_load_done, core_proc_done, 1'b0};
   assign busy       = !(state == IDLE || state == DONE);
   assign start_ok   = cfg_start && !busy;
   assign last_load  = idx == 5'(CORE_NUM - 1);
   assign store_edge = core_store_done && !store_prev;
   assign ack_ok     = state == FRAG_READY && frag_ack;
   assign last_frag  = frag_cnt + 22'd1 == 22'(FRAG_NUM);
   assign core_cs         = state == LOAD;
   assign core_add        = core_cs ? idx : 5'd0;
   assign core_data       = core_cs ? prime_tab[idx] : 32'd0;
   assign core_kick_start = state == KICK;
   assign frag_ready      = state == FRAG_READY;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = start_ok ? LOAD : state;
         LOAD:       state_nx = last_load ? KICK : LOAD;
         KICK:       state_nx = WAIT_STORE;
         WAIT_STORE: state_nx = store_edge ? FRAG_READY : WAIT_STORE;
         FRAG_READY: state_nx = frag_ack ? (last_frag ? DONE : KICK) : FRAG_READY;
         default:    state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         idx             <= 5'd0;
         store_prev      <= 1'b0;
         frag_cnt        <= 22'd0;
         core_start_addr <= 64'd0;
         intr            <= 1'b0;
         rd_data         <= 32'd0;
      end else begin
         state      <= state_nx;
         store_prev <= core_store_done;
         if (start_ok) begin
            idx             <= 5'd0;
            frag_cnt        <= 22'd0;
            core_start_addr <= cfg_base_addr;
         end else if (state == LOAD) idx <= idx + 5'd1;
         if (ack_ok) begin
            frag_cnt        <= frag_cnt + 22'd1;
            core_start_addr <= core_start_addr + ADDR_STEP;
         end
         // a set event outranks a same-cycle clear
         intr <= (ack_ok && last_frag) || (intr && !intr_clr && !start_ok);
         if (rd_en) rd_data <= res_buf[rd_addr];
      end
   end
   always_ff @(posedge clk) begin
      if (prime_we && !busy) prime_tab[prime_idx] <= prime_data;
      if (res_cs) res_buf[res_add] <= res_data;
   end
endmodule

// File: tb/tb_gatebach_host.sv
// tb_gatebach_host: directed bench; unit a runs CORE_NUM=3/FRAG_NUM=2, unit b runs CORE_NUM=1/FRAG_NUM=1
// on the same inputs.
module tb_gatebach_host;
   logic clk = 0, rst_n = 0;
   logic cfg_start = 0, prime_we = 0, rd_en = 0, frag_ack = 0, intr_clr = 0;
   logic core_store_done = 0, res_cs = 0;
   logic [63:0] cfg_base_addr = 64'hC9;
   logic [4:0]  prime_idx = 0;
   logic [31:0] prime_data = 0, res_data = 0;
   logic [5:0]  rd_addr = 0, res_add = 0;
   logic [31:0] a_rd_data, a_core_data, b_rd_data, b_core_data;
   logic        a_frag_ready, a_busy, a_intr, a_core_cs, a_kick;
   logic        b_frag_ready, b_busy, b_intr, b_core_cs, b_kick;
   logic [21:0] a_frag_cnt, b_frag_cnt;
   logic [4:0]  a_core_add, b_core_add;
   logic [63:0] a_addr, b_addr;
   int errs = 0, checks = 0;

   always #5 clk = ~clk;

   gatebach_host #(.CORE_NUM(3), .FRAG_NUM(2)) u_a (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
      .prime_we(prime_we), .prime_idx(prime_idx), .prime_data(prime_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .frag_ready(a_frag_ready),
      .frag_ack(frag_ack), .frag_cnt(a_frag_cnt), .busy(a_busy), .intr(a_intr), .intr_clr(intr_clr),
      .core_cs(a_core_cs), .core_add(a_core_add), .core_data(a_core_data),
      .core_start_addr(a_addr), .core_kick_start(a_kick), .core_store_done(core_store_done),
      .core_load_done(1'b0), .core_proc_done(1'b0),
      .res_cs(res_cs), .res_add(res_add), .res_data(res_data));

   gatebach_host #(.CORE_NUM(1), .FRAG_NUM(1)) u_b (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
      .prime_we(prime_we), .prime_idx(prime_idx), .prime_data(prime_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .frag_ready(b_frag_ready),
      .frag_ack(frag_ack), .frag_cnt(b_frag_cnt), .busy(b_busy), .intr(b_intr), .intr_clr(intr_clr),
      .core_cs(b_core_cs), .core_add(b_core_add), .core_data(b_core_data),
      .core_start_addr(b_addr), .core_kick_start(b_kick), .core_store_done(core_store_done),
      .core_load_done(1'b0), .core_proc_done(1'b0),
      .res_cs(res_cs), .res_add(res_add), .res_data(res_data));

   typedef struct {
      logic st, we;
      logic cs; logic [4:0] add; logic [31:0] data; logic kick, busy;
      logic bcs; logic [31:0] bdata; logic bkick;
   } vec_t;
   vec_t v [5];

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      v[0] = '{st:1, we:0, cs:1, add:0, data:5,  kick:0, busy:1, bcs:1, bdata:5, bkick:0};
      v[1] = '{st:0, we:1, cs:1, add:1, data:7,  kick:0, busy:1, bcs:0, bdata:0, bkick:1};
      v[2] = '{st:1, we:0, cs:1, add:2, data:11, kick:0, busy:1, bcs:0, bdata:0, bkick:0};
      v[3] = '{st:0, we:0, cs:0, add:0, data:0,  kick:1, busy:1, bcs:0, bdata:0, bkick:0};
      v[4] = '{st:0, we:0, cs:0, add:0, data:0,  kick:0, busy:1, bcs:0, bdata:0, bkick:0};
      step(); step();
      chk("rst_busy", a_busy, 0);
      chk("rst_cs", a_core_cs, 0);
      chk("rst_kick", a_kick, 0);
      chk("rst_ready", a_frag_ready, 0);
      chk("rst_intr", a_intr, 0);
      chk("rst_addr", a_addr, 0);
      chk("rst_cnt", a_frag_cnt, 0);
      chk("rst_rd", a_rd_data, 0);
      rst_n = 1;
      step();
      for (int i = 0; i < 3; i++) begin
         prime_we = 1; prime_idx = 5'(i);
         prime_data = (i == 0) ? 32'd5 : (i == 1) ? 32'd7 : 32'd11;
         step();
      end
      prime_we = 0;
      for (int i = 0; i < 5; i++) begin
         cfg_start = v[i].st; prime_we = v[i].we; prime_idx = 5'd1; prime_data = 32'd99;
         step();
         chk($sformatf("v%0d_cs", i), a_core_cs, v[i].cs);
         chk($sformatf("v%0d_add", i), a_core_add, v[i].add);
         chk($sformatf("v%0d_data", i), a_core_data, v[i].data);
         chk($sformatf("v%0d_kick", i), a_kick, v[i].kick);
         chk($sformatf("v%0d_busy", i), a_busy, v[i].busy);
         chk($sformatf("v%0d_bcs", i), b_core_cs, v[i].bcs);
         chk($sformatf("v%0d_bdata", i), b_core_data, v[i].bdata);
         chk($sformatf("v%0d_bkick", i), b_kick, v[i].bkick);
         chk($sformatf("v%0d_addr", i), a_addr, 64'hC9);
         chk($sformatf("v%0d_baddr", i), b_addr, 64'hC9);
      end
      cfg_start = 0; prime_we = 0;
      for (int i = 0; i < 64; i++) begin
         res_cs = 1; res_add = 6'(i); res_data = 32'(i * 3);
         step();
      end
      res_cs = 0;
      chk("pre_store_ready", a_frag_ready, 0);
      core_store_done = 1;
      step();
      chk("store_ready", a_frag_ready, 1);
      chk("store_bready", b_frag_ready, 1);
      rd_en = 1; rd_addr = 0;
      step();
      chk("rd0", a_rd_data, 0);
      rd_addr = 63;
      step();
      chk("rd63", a_rd_data, 189);
      rd_en = 0; rd_addr = 5;
      step();
      chk("rd_hold", a_rd_data, 189);
      frag_ack = 1;
      step();
      frag_ack = 0;
      chk("ack1_ready", a_frag_ready, 0);
      chk("ack1_kick", a_kick, 1);
      chk("ack1_cnt", a_frag_cnt, 1);
      chk("ack1_addr", a_addr, 64'hC9 + 64'd4096);
      chk("ack1_intr", a_intr, 0);
      chk("b_intr", b_intr, 1);
      chk("b_cnt", b_frag_cnt, 1);
      chk("b_busy", b_busy, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("held_store_%0d", i), a_frag_ready, 0);
      end
      core_store_done = 0;
      step();
      core_store_done = 1;
      step();
      chk("store2_ready", a_frag_ready, 1);
      frag_ack = 1; intr_clr = 1;
      step();
      frag_ack = 0; intr_clr = 0;
      chk("ack2_intr", a_intr, 1);
      chk("ack2_cnt", a_frag_cnt, 2);
      chk("ack2_busy", a_busy, 0);
      chk("ack2_addr", a_addr, 64'hC9 + 64'd8192);
      chk("b_intr_clr", b_intr, 0);
      frag_ack = 1;
      step();
      frag_ack = 0;
      chk("ack_idle_cnt", a_frag_cnt, 2);
      intr_clr = 1;
      step();
      intr_clr = 0;
      chk("intr_clr", a_intr, 0);
      prime_we = 1; prime_idx = 0; prime_data = 13;
      step();
      prime_we = 0; cfg_start = 1; cfg_base_addr = 64'h500;
      step();
      cfg_start = 0;
      chk("job2_data", a_core_data, 13);
      chk("job2_addr", a_addr, 64'h500);
      chk("job2_cnt", a_frag_cnt, 0);
      step(); step(); step(); step();
      chk("job2_busy", a_busy, 1);
      #2 rst_n = 0;
      #1;
      chk("arst_busy", a_busy, 0);
      chk("arst_addr", a_addr, 0);
      chk("arst_cs", a_core_cs, 0);
      chk("arst_kick", a_kick, 0);
      chk("arst_ready", a_frag_ready, 0);
      chk("arst_intr", a_intr, 0);
      step();
      rst_n = 1;
      cfg_start = 1; cfg_base_addr = 64'hC9;
      step();
      cfg_start = 0;
      chk("fresh_cs", a_core_cs, 1);
      chk("fresh_data", a_core_data, 13);
      step(); step();
      chk("fresh_add2", a_core_add, 2);
      step();
      chk("fresh_kick", a_kick, 1);
      chk("fresh_addr", a_addr, 64'hC9);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
